// File: rtl/duty_ramp_ctrl.sv
// Duty-cycle slew controller feeding the PWM stage: soft-start/stop ramp with IR obstacle stop and recovery.
// Optional IR_DEBOUNCE_EN adds a stable-time filter of DEBOUNCE_CYCLES clocks on the synchronised IR level.
module duty_ramp_ctrl #(
  parameter int STEP_DIV        = 1000,
  parameter int STEP_SIZE       = 1,
  parameter int CLEAR_TICKS     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] target,
  input  logic       ir,
  output logic [7:0] duty_cycle,
  output logic       at_target,
  output logic       blocked
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(STEP_DIV - 1);
  localparam logic [8:0] STEP9  = 9'(STEP_SIZE);
  localparam logic [8:0] CLEAR9 = 9'(CLEAR_TICKS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BLOCKED, ST_RECOVER} state_t;

  state_t     state_q, state_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] clr_q, clr_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic       tick_s;
  logic       sync1_q, sync2_q;
  logic       ir_s;
  logic [8:0] duty9_s, tgt9_s, up9_s, clr_inc9_s;
  logic [7:0] ramp_s;

  // Free-running ramp tick divider
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CW'(1);
    end
  end

  // Tick counter and IR synchroniser flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= ir;
      sync2_q    <= sync1_q;
    end
  end

`ifdef IR_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_q, db_d;

  // Filtered level flips only after the synchronised level differs for DEBOUNCE_CYCLES clocks in a row
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign ir_s = db_q;
`else
  assign ir_s = sync2_q;
`endif

  // Saturating ramp toward target using 9-bit headroom so duty never wraps
  always_comb begin
    duty9_s = {1'b0, duty_q};
    tgt9_s  = {1'b0, target};
    up9_s   = duty9_s + STEP9;
    if (duty9_s < tgt9_s) begin
      ramp_s = (up9_s > tgt9_s) ? target : up9_s[7:0];
    end else if (duty9_s > tgt9_s) begin
      ramp_s = (duty9_s < (tgt9_s + STEP9)) ? target : (duty_q - STEP9[7:0]);
    end else begin
      ramp_s = duty_q;
    end
  end

  // Next-state and duty decode, priority: enable drop, idle start, obstacle, per-state behaviour
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    clr_d      = clr_q;
    clr_inc9_s = {1'b0, clr_q} + 9'd1;
    if (!enable) begin
      state_d = ST_IDLE;
      duty_d  = 8'd0;
      clr_d   = 8'd0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
      duty_d  = 8'd0;
    end else if (ir_s) begin
      state_d = ST_BLOCKED;
      duty_d  = 8'd0;
      clr_d   = 8'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_s) begin
            duty_d = ramp_s;
          end else begin
            duty_d = duty_q;
          end
        end
        ST_BLOCKED: begin
          state_d = ST_RECOVER;
          duty_d  = 8'd0;
          clr_d   = 8'd0;
        end
        ST_RECOVER: begin
          duty_d = 8'd0;
          if (tick_s) begin
            if (clr_inc9_s >= CLEAR9) begin
              state_d = ST_RUN;
              clr_d   = 8'd0;
            end else begin
              clr_d = clr_inc9_s[7:0];
            end
          end else begin
            clr_d = clr_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = 8'd0;
          clr_d   = 8'd0;
        end
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q  <= 8'd0;
      clr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      clr_q   <= clr_d;
    end
  end

  assign duty_cycle = duty_q;
  assign at_target  = (state_q == ST_RUN) && (duty_q == target);
  assign blocked    = (state_q == ST_BLOCKED) || (state_q == ST_RECOVER);

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Self-checking bench for duty_ramp_ctrl: directed test-plan scenarios then random stimulus against a behavioural model.
// Build with IR_DEBOUNCE_EN defined to exercise the debounce scenario.
module tb_duty_ramp_ctrl;

  localparam int STEP_DIV    = 4;
  localparam int STEP_SIZE   = 10;
  localparam int CLEAR_TICKS = 2;
  localparam int DEB         = 16;
`ifdef IR_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_BLK = 2, M_REC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] target = 8'd0;
  logic       ir = 1'b0;
  logic [7:0] duty_cycle;
  logic       at_target;
  logic       blocked;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int m_mode, m_duty, m_clr, m_n;
  bit m_s1, m_s2, m_filt;
  bit win[$];

  duty_ramp_ctrl #(
    .STEP_DIV(STEP_DIV), .STEP_SIZE(STEP_SIZE),
    .CLEAR_TICKS(CLEAR_TICKS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .target(target), .ir(ir),
    .duty_cycle(duty_cycle), .at_target(at_target), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_duty = 0; m_clr = 0; m_n = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_filt = 1'b0;
    win.delete();
  endtask

  // one clock edge of the reference behaviour, given the inputs seen at that edge
  task automatic model_step(input bit en, input int tgt, input bit irv);
    bit tick;
    bit irs;
    bit same;
    tick = (m_n % STEP_DIV) == (STEP_DIV - 1);
`ifdef IR_DEBOUNCE_EN
    irs = m_filt;
`else
    irs = m_s2;
`endif
    if (!en) begin
      m_mode = M_IDLE; m_duty = 0; m_clr = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_RUN; m_duty = 0;
    end else if (irs) begin
      m_mode = M_BLK; m_duty = 0; m_clr = 0;
    end else if (m_mode == M_RUN) begin
      if (tick) begin
        if (m_duty < tgt) m_duty = (m_duty + STEP_SIZE > tgt) ? tgt : m_duty + STEP_SIZE;
        else if (m_duty > tgt) m_duty = (m_duty - STEP_SIZE < tgt) ? tgt : m_duty - STEP_SIZE;
      end
    end else if (m_mode == M_BLK) begin
      m_mode = M_REC; m_clr = 0;
    end else if (m_mode == M_REC) begin
      if (tick) begin
        m_clr++;
        if (m_clr >= CLEAR_TICKS) begin
          m_mode = M_RUN; m_clr = 0;
        end
      end
    end
`ifdef IR_DEBOUNCE_EN
    win.push_back(m_s2);
    if (win.size() > DEB) void'(win.pop_front());
    same = (win.size() == DEB);
    foreach (win[k]) if (win[k] != m_s2) same = 1'b0;
    if (same && (m_s2 != m_filt)) m_filt = m_s2;
`else
    same = 1'b0;
`endif
    m_s2 = m_s1;
    m_s1 = irv;
    m_n++;
  endtask

  // drive one clock of inputs (called at negedge) and check outputs at the following negedge
  task automatic cycle(input bit en, input int tgt, input bit irv);
    enable = en;
    target = 8'(tgt);
    ir = irv;
    model_step(en, tgt, irv);
    @(posedge clk);
    @(negedge clk);
    chk("duty", 32'(duty_cycle), 32'(m_duty));
    chk("at_target", 32'(at_target), 32'(m_mode == M_RUN && m_duty == tgt));
    chk("blocked", 32'(blocked), 32'(m_mode == M_BLK || m_mode == M_REC));
  endtask

  // async reset asserted mid-cycle, outputs checked before any clock edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_duty", 32'(duty_cycle), 32'd0);
    chk("rst_at_target", 32'(at_target), 32'd0);
    chk("rst_blocked", 32'(blocked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit en_r;
    bit ir_r;
    int tgt_r;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: first ramp to 35
    repeat (16) cycle(1'b1, 35, 1'b0);
    chk("ramp_up_35", 32'(duty_cycle), 32'd35);
    chk("at_target_35", 32'(at_target), 32'd1);

    // 2: ramp down, saturate at 255, ramp to 0
    repeat (12) cycle(1'b1, 5, 1'b0);
    chk("ramp_down_5", 32'(duty_cycle), 32'd5);
    repeat (100) cycle(1'b1, 250, 1'b0);
    chk("reach_250", 32'(duty_cycle), 32'd250);
    repeat (4) cycle(1'b1, 255, 1'b0);
    chk("sat_255", 32'(duty_cycle), 32'd255);
    repeat (112) cycle(1'b1, 0, 1'b0);
    chk("zero_duty", 32'(duty_cycle), 32'd0);
    chk("zero_at_target", 32'(at_target), 32'd1);

    // 3: obstacle mid-ramp at duty 20
    for (int i = 0; i < 40 && m_duty != 20; i++) cycle(1'b1, 35, 1'b0);
    chk("reach_20", 32'(duty_cycle), 32'd20);
    repeat (LAT - 1) cycle(1'b1, 35, 1'b1);
    chk("blk_before_lat", 32'(blocked), 32'd0);
    cycle(1'b1, 35, 1'b1);
    chk("blk_at_lat", 32'(blocked), 32'd1);
    chk("blk_duty0", 32'(duty_cycle), 32'd0);
    repeat (4) cycle(1'b1, 35, 1'b1);
    repeat (LAT + 3 * STEP_DIV) cycle(1'b1, 35, 1'b0);
    chk("recovered", 32'(blocked), 32'd0);
    repeat (10) cycle(1'b1, 35, 1'b0);

    // 4: re-block after one clear tick
    repeat (LAT + 1) cycle(1'b1, 35, 1'b1);
    for (int i = 0; i < 80 && !(m_mode == M_REC && m_clr == 1); i++) cycle(1'b1, 35, 1'b0);
    chk("rec_one_tick", 32'(blocked), 32'd1);
    repeat (LAT) cycle(1'b1, 35, 1'b1);
    chk("reblocked", 32'(blocked), 32'd1);
    repeat (LAT + 3 * STEP_DIV) cycle(1'b1, 35, 1'b0);
    chk("recovered2", 32'(blocked), 32'd0);

    // 5: enable drop while blocked, ir ignored in idle, async reset mid-ramp
    repeat (LAT + 1) cycle(1'b1, 35, 1'b1);
    cycle(1'b0, 35, 1'b1);
    chk("idle_unblocked", 32'(blocked), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 35, 1'(i % 2));
    repeat (LAT + 1) cycle(1'b0, 35, 1'b0);
    for (int i = 0; i < 40 && m_duty != 30; i++) cycle(1'b1, 35, 1'b0);
    chk("reach_30", 32'(duty_cycle), 32'd30);
    do_reset();

`ifdef IR_DEBOUNCE_EN
    // 6: short glitch filtered, long pulse blocks at edge 19
    repeat (40) cycle(1'b1, 200, 1'b0);
    repeat (10) cycle(1'b1, 200, 1'b1);
    repeat (30) cycle(1'b1, 200, 1'b0);
    chk("glitch_ignored", 32'(blocked), 32'd0);
    repeat (18) cycle(1'b1, 200, 1'b1);
    chk("deb_edge18", 32'(blocked), 32'd0);
    cycle(1'b1, 200, 1'b1);
    chk("deb_edge19", 32'(blocked), 32'd1);
    chk("deb_duty0", 32'(duty_cycle), 32'd0);
    repeat (LAT + 3 * STEP_DIV) cycle(1'b1, 200, 1'b0);
`endif

    // random phase
    en_r = 1'b1; ir_r = 1'b0; tgt_r = 128;
    repeat (2500) begin
      if (en_r && $urandom_range(0, 299) == 0) en_r = 1'b0;
      else if (!en_r && $urandom_range(0, 19) == 0) en_r = 1'b1;
      if ($urandom_range(0, 24) == 0) tgt_r = int'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0) ir_r = !ir_r;
      if ($urandom_range(0, 699) == 0) do_reset();
      cycle(en_r, tgt_r, ir_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/duty_ramp_ctrl.md
Name: duty_ramp_ctrl

Overview:
Speed-command stage that sits directly upstream of the PWM generator and drives its 8-bit duty_cycle input. It slews duty_cycle toward a requested target at a programmable rate to give motor soft-start and soft-stop. It also synchronises the IR obstacle input, forces duty to 0 while an obstacle is present, and restarts from 0 only after the path has stayed clear for a fixed number of ramp ticks.

Parameters:
STEP_DIV, 1000, clocks per ramp tick (>=2)
STEP_SIZE, 1, duty change per tick (1..255)
CLEAR_TICKS, 4, consecutive clear ticks required before restart (1..255)
DEBOUNCE_CYCLES, 16, IR stable-time in clocks; used only with IR_DEBOUNCE_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
enable  in  1  run request; low forces IDLE
target  in  8  requested duty, 0..255
ir  in  1  raw obstacle sensor, high = obstacle, asynchronous
duty_cycle  out  8  duty command to the PWM stage
at_target  out  1  high when state==RUN and duty_cycle==target
blocked  out  1  high in BLOCKED or RECOVER

Behaviour:
- Reset state: duty_cycle=0, state=IDLE, tick counter=0, clear count=0, sync flops=0, at_target=0, blocked=0.
- Reset is asynchronous and takes effect mid-ramp or mid-recovery with no residual state.
- Tick generator: free-running counter 0..STEP_DIV-1. Pulse tick=1 for one clock when the count equals STEP_DIV-1, then wrap to 0. It runs in every state.
- IR path: 2-flop synchroniser produces ir_s. Raw ir rising -> duty_cycle=0 at the 3rd rising clk edge after ir rises.
- States and transitions, highest priority first:
  - enable=0 in any state -> IDLE next edge, duty_cycle=0 on that edge.
  - IDLE: duty_cycle holds 0. ir is ignored. enable=1 -> RUN.
  - Any state except IDLE with ir_s=1 -> BLOCKED, duty_cycle=0 on the same edge, clear count=0.
  - RUN: on tick, if duty<target, duty=min(duty+STEP_SIZE, target). If duty>target, duty=max(duty-STEP_SIZE, target). If equal, duty holds. Use 9-bit intermediate arithmetic; duty never wraps past 255 or below 0.
  - RUN: target is sampled only on tick and may change at any time.
  - BLOCKED: duty_cycle=0. ir_s=0 -> RECOVER with clear count=0.
  - RECOVER: duty_cycle=0. On each tick with ir_s=0, clear count increments. When count reaches CLEAR_TICKS -> RUN, with duty starting from 0 and ramping at the next tick. ir_s=1 -> BLOCKED and count clears.
- Between ticks, duty_cycle changes only on forced-zero events.
- at_target and blocked are decoded combinationally from registered state and duty; neither has a registered delay.
- target=0 in RUN: duty ramps down to 0, state stays RUN, at_target=1.

Optional Feature:
IR_DEBOUNCE_EN
- Defined: ir_s changes only after the 2-flop synchronised value has held a new level for DEBOUNCE_CYCLES consecutive clocks. Glitches shorter than that are ignored. Obstacle latency becomes 3+DEBOUNCE_CYCLES clocks.
- Undefined: ir_s is the 2-flop synchronised value directly, with no stable-time filtering.

Test Plan:
All scenarios use STEP_DIV=4, STEP_SIZE=10, CLEAR_TICKS=2.
1. Reset and first ramp: pulse rst, then set enable=1, target=35 -> duty_cycle=0 after reset. duty_cycle then steps 10, 20, 30, 35 on successive ticks, 4 clks apart. at_target=1 from the cycle duty reaches 35.
2. Ramp down and saturation: target 35 -> 5 gives duty 25, 15, 5. Then target=255 from duty 250 gives 255 with no wrap. Then target=0 ramps to 0 with at_target=1.
3. Obstacle stop: ir=1 mid-ramp at duty 20 -> duty_cycle=0 and blocked=1 at the 3rd edge. ir=0 -> RECOVER. After 2 clear ticks, state is RUN, blocked=0, and duty ramps 10, 20, ...
4. Re-block during recovery: ir=1 after 1 clear tick -> BLOCKED and count clears. After ir=0, 2 full clear ticks are again needed before RUN.
5. Enable drop and async reset: enable=0 while BLOCKED -> IDLE, blocked=0, duty=0, and ir toggling is ignored. Assert rst mid-ramp at duty 30 -> all outputs 0 immediately, without waiting for a clock edge.
6. IR_DEBOUNCE_EN with DEBOUNCE_CYCLES=16: a 10-clk ir pulse -> no duty change. A 20-clk ir pulse -> duty=0 at edge 19 after ir rises.
